// File: rtl/bcast_fork_array_if.sv
// Per-channel valid/ready link carrying one broadcast word.
// The Tx side is the fork (producer); the Rx side is the consumer.
interface bcast_fork_array_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport Tx (output valid, output data, input ready);
  modport Rx (input valid, input data, output ready);
endinterface

// File: rtl/bcast_fork_array.sv
// Broadcast fork: one upstream word is held and delivered once to each destination channel.
// Optional feature: define BCAST_FORK_MASK_EN to add i_mask, a per-word destination mask.
module bcast_fork_array #(
  parameter int NCHAN = 8,
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTH-1:0]  i_data,
`ifdef BCAST_FORK_MASK_EN
  input  logic [NCHAN-1:0]  i_mask,
`endif
  bcast_fork_array_if.Tx    p [NCHAN],
  output logic              o_busy,
  output logic [CNTW-1:0]   o_count
);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic [NCHAN-1:0] pend_q, pend_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [NCHAN-1:0] ready_v;
  logic [NCHAN-1:0] dest_mask;
  logic             accept;
  logic             word_done;

  // Interface arrays need constant indices, so fan out per channel here.
  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    assign p[g].valid = pend_q[g];
    assign p[g].data  = hold_q;
    assign ready_v[g] = p[g].ready;
  end

`ifdef BCAST_FORK_MASK_EN
  assign dest_mask = i_mask;
`else
  assign dest_mask = '1;
`endif

  // A word is complete when every still-pending channel handshakes now;
  // that is also exactly when the holding register may take a new word.
  assign o_ready   = ((pend_q & ~ready_v) == '0);
  assign accept    = i_valid && o_ready;
  assign word_done = (pend_q != '0) && o_ready;
  assign o_busy    = (pend_q != '0);
  assign o_count   = count_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    pend_d  = pend_q & ~ready_v;
    hold_d  = hold_q;
    count_d = count_q;
    if (accept) begin
      // A freshly accepted mask overrides the clears of the word just finishing.
      pend_d = dest_mask;
      hold_d = i_data;
    end
    if (word_done) begin
      count_d = count_q + CNTW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
    if (!i_rst_n) begin
      pend_q  <= '0;
      hold_q  <= '0;
      count_q <= '0;
    end else begin
      pend_q  <= pend_d;
      hold_q  <= hold_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_bcast_fork_array.sv
// Scoreboard bench for bcast_fork_array: per-channel expected-word queues fed on accept,
// drained by a negedge monitor on every channel handshake.
module tb_bcast_fork_array;
  localparam int NCH = 8;
  localparam int W   = 8;
  localparam int CW  = 16;
  localparam int CWS = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_valid;
  logic [W-1:0]   i_data;
  logic [NCH-1:0] rdy;
  logic [NCH-1:0] mask_v;
  logic           o_ready, o_ready_w, o_busy, o_busy_w;
  logic [CW-1:0]  o_count;
  logic [CWS-1:0] o_count_w;
  logic [NCH-1:0] vld;
  logic [W-1:0]   dat [NCH];

  int errors = 0;
  int checks = 0;

  // Reference model: one queue of undelivered words per channel.
  logic [W-1:0] exp_q [NCH][$];
  int out_left = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  bcast_fork_array_if #(.WIDTH(W)) ch  [NCH] ();
  bcast_fork_array_if #(.WIDTH(W)) chw [NCH] ();

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ch[g].ready  = rdy[g];
    assign chw[g].ready = rdy[g];
    assign vld[g]       = ch[g].valid;
    assign dat[g]       = ch[g].data;
  end

  bcast_fork_array #(.NCHAN(NCH), .WIDTH(W), .CNTW(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
`ifdef BCAST_FORK_MASK_EN
    .i_mask  (mask_v),
`endif
    .p       (ch),
    .o_busy  (o_busy),
    .o_count (o_count)
  );

  // Narrow-counter copy on identical stimulus, used for the wrap behaviour.
  bcast_fork_array #(.NCHAN(NCH), .WIDTH(W), .CNTW(CWS)) dut_w (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready_w),
    .i_data  (i_data),
`ifdef BCAST_FORK_MASK_EN
    .i_mask  (mask_v),
`endif
    .p       (chw),
    .o_busy  (o_busy_w),
    .o_count (o_count_w)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against the model, then apply this cycle's events.
  always @(negedge clk) begin : monitor
    logic [NCH-1:0] ev;
    logic [NCH-1:0] m;
    logic [W-1:0]   any_dat;
    bit             er;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) exp_q[i].delete();
      out_left = 0;
      exp_cnt  = 0;
      any_dat  = '0;
      for (int i = 0; i < NCH; i++) any_dat |= dat[i];
      check("rst_valid", vld, 0);
      check("rst_data", any_dat, 0);
      check("rst_busy", o_busy, 0);
      check("rst_ready", o_ready, 1);
      check("rst_count", o_count, 0);
    end else begin
      er = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        ev[i] = (exp_q[i].size() != 0);
        if (ev[i] && !rdy[i]) er = 1'b0;
      end
      check("valid", vld, ev);
      check("busy", o_busy, ev != '0);
      check("ready", o_ready, er);
      check("ready_w", o_ready_w, er);
      check("busy_w", o_busy_w, ev != '0);
      check("count", o_count, exp_cnt % (1 << CW));
      check("count_w", o_count_w, exp_cnt % (1 << CWS));
      for (int i = 0; i < NCH; i++) begin
        if (ev[i] && rdy[i]) begin
          check($sformatf("data_ch%0d", i), dat[i], exp_q[i].pop_front());
          out_left--;
          if (out_left == 0) exp_cnt++;
        end
      end
      if (i_valid && er) begin
`ifdef BCAST_FORK_MASK_EN
        m = mask_v;
`else
        m = '1;
`endif
        out_left = $countones(m);
        for (int i = 0; i < NCH; i++) if (m[i]) exp_q[i].push_back(i_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    i_valid = 1'b0;
    rdy     = '1;
    mask_v  = '1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic stream(input int n, output int acc);
    acc = 0;
    for (int k = 1; k <= n; k++) begin
      i_valid = 1'b1;
      i_data  = W'(k);
      @(negedge clk);
      if (o_ready) acc++;
      tick();
    end
    i_valid = 1'b0;
  endtask

  initial begin
    int acc, lows;
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; rdy = '1; mask_v = '1;

    // Reset then idle.
    do_reset();
    repeat (3) tick();
    check("idle_ready", o_ready, 1);
    check("idle_busy", o_busy, 0);
    check("idle_valid", vld, 0);
    check("idle_count", o_count, 0);

    // Streaming 0x01..0x10 back to back with all channels ready.
    stream(16, acc);
    tick();
    check("stream_accepted", acc, 16);
    check("stream_count", o_count, 16);

    // Channel 3 stalls for 5 cycles on word 0xA5.
    do_reset();
    rdy = 8'hF7; i_valid = 1'b1; i_data = 8'hA5;
    tick();
    i_valid = 1'b0;
    lows = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (!o_ready) lows++;
      tick();
      if (j == 0) check("stall_others_done", vld, 8'h08);
    end
    check("stall_ready_low_cycles", lows, 5);
    check("stall_count_before", o_count, 0);
    rdy = '1;
    @(negedge clk);
    check("stall_ready_release", o_ready, 1);
    tick();
    check("stall_count_after", o_count, 1);
    check("stall_valid_after", vld, 0);

    // Counter wrap on the 4-bit copy.
    do_reset();
    stream(17, acc);
    tick();
    check("wrap_count_w", o_count_w, 1);
    check("wrap_count", o_count, 17);

    // Reset while channel 0 still owes a handshake.
    do_reset();
    rdy = 8'hFE; i_valid = 1'b1; i_data = 8'h5A;
    tick();
    i_valid = 1'b0;
    tick();
    check("mid_pending", vld, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", vld, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_ready", o_ready, 1);
    check("mid_rst_count", o_count, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    rdy = '1;
    tick();

`ifdef BCAST_FORK_MASK_EN
    // Masked delivery and an empty mask.
    do_reset();
    mask_v = 8'h05; i_valid = 1'b1; i_data = 8'h3C; rdy = '0;
    tick();
    i_valid = 1'b0;
    check("mask_valid", vld, 8'h05);
    rdy = '1;
    tick();
    mask_v = '0; i_valid = 1'b1; i_data = 8'h77;
    tick();
    i_valid = 1'b0;
    check("mask_zero_valid", vld, 0);
    check("mask_zero_count", o_count, 1);
    mask_v = '1;
`endif

    // Randomised traffic with random back-pressure.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rdy     = NCH'($urandom | $urandom);
      i_valid = ($urandom_range(0, 3) != 0);
      i_data  = W'($urandom);
      mask_v  = ($urandom_range(0, 4) == 0) ? '0 : NCH'($urandom);
      tick();
    end
    i_valid = 1'b0;
    rdy     = '1;
    repeat (3) tick();
    check("drain_busy", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcast_fork_array.md
BCAST_FORK_ARRAY -- requirements
Module: bcast_fork_array

Interface
REQ-001 Parameter NCHAN, default 8: number of output channels (1..32).
REQ-002 Parameter WIDTH, default 8: payload width in bits (1..64).
REQ-003 Parameter CNTW, default 16: width of the completed-transfer counter.
REQ-004 i_clk  input  1  sole clock; all state on rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_valid  input  1  upstream word valid.
REQ-007 o_ready  output  1  upstream word accepted when i_valid && o_ready.
REQ-008 i_data  input  WIDTH  upstream payload.
REQ-009 p  interface array [NCHAN], modport Tx  per channel: valid output 1, data output WIDTH, ready input 1.
REQ-010 o_busy  output  1  high while any channel delivery is outstanding.
REQ-011 o_count  output  CNTW  number of fully delivered words, modulo 2^CNTW.

Function
REQ-012 Holding register hold_q (WIDTH) and pending mask pend_q (NCHAN) SHALL form the only datapath state.
REQ-013 Upstream accept: on i_valid && o_ready, i_data SHALL load hold_q and pend_q SHALL load the destination mask (all ones unless REQ-027 applies).
REQ-014 p[i].valid SHALL equal pend_q[i]; p[i].data SHALL equal hold_q for every i.
REQ-015 Channel i handshake: p[i].valid && p[i].ready SHALL clear pend_q[i] at the next edge; no channel SHALL see the same word twice.
REQ-016 Latency: a word accepted at edge N SHALL be visible on every destination channel from the cycle after edge N.
REQ-017 o_ready SHALL be combinational: 1 when every set bit of pend_q is handshaking this cycle (including pend_q == 0), else 0.
REQ-018 Simultaneous final handshake and upstream accept in one cycle: the new word SHALL load and the new mask SHALL override clears; throughput SHALL be one word per cycle when all channels hold ready high.
REQ-019 Channels SHALL complete in any order and any cycle; a stalled channel SHALL NOT block other channels' delivery of the current word.
REQ-020 o_count SHALL increment by 1 in the cycle pend_q transitions from nonzero to zero, and SHALL wrap from 2^CNTW-1 to 0.
REQ-021 o_busy SHALL equal (pend_q != 0).
REQ-022 hold_q SHALL not change while pend_q != 0 unless REQ-018 applies.

Reset
REQ-023 Asserting i_rst_n low SHALL immediately clear pend_q, hold_q and o_count to 0, independent of i_clk.
REQ-024 During and after reset: all p[i].valid = 0, p[i].data = 0, o_busy = 0, o_count = 0, o_ready = 1.
REQ-025 Reset mid-delivery SHALL discard the outstanding word without incrementing o_count.
REQ-026 Deassertion SHALL take effect on the first i_clk rising edge with i_rst_n high.

Configuration
REQ-027 Macro BCAST_FORK_MASK_EN defined: extra input i_mask (NCHAN) SHALL be sampled with the accepted word and loaded into pend_q; a zero mask SHALL accept the word without delivery or o_count increment.
REQ-028 Macro BCAST_FORK_MASK_EN undefined: i_mask SHALL not exist; every accepted word SHALL target all NCHAN channels.

Verification
REQ-029 Reset then idle: all p[i].ready = 1, i_valid = 0 -> o_ready = 1, o_busy = 0, all p[i].valid = 0, o_count = 0.
REQ-030 Streaming, NCHAN=8: i_data 0x01..0x10 on consecutive cycles, all ready high -> 16 words accepted in 16 cycles, each channel receives 0x01..0x10 in order, o_count = 16.
REQ-031 Stall: word 0xA5, p[3].ready low for 5 cycles -> other 7 channels complete in 1 cycle, o_ready = 0 for 5 cycles, o_count increments once when p[3] handshakes.
REQ-032 Wrap: CNTW=4, deliver 17 words -> o_count = 1.
REQ-033 Reset mid-delivery: p[0].ready low, pend_q nonzero, pulse i_rst_n low -> all valids drop asynchronously, o_count unchanged at 0, o_ready = 1.
REQ-034 With BCAST_FORK_MASK_EN: i_mask = 8'h05, word 0x3C -> only p[0] and p[2] assert valid; i_mask = 0 -> word accepted, no valid, o_count unchanged.
